gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised multi-pin GPIO peripheral for the rv32i SoC memory-mapped bus. Provides WIDTH tri-state pins with per-pin output value and output enable, atomic set/clear of output bits, a metastability-hardened input path, and per-pin rising/falling edge interrupts with write-1-to-clear status. It sits behind the system bus decoder alongside the other peripherals and drives a single level interrupt line to the core.

## Interface
- WIDTH, 8, number of GPIO pins (1..32); register bits above WIDTH-1 read 0, writes ignored
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock domain only
- wen  input  1  write strobe, single cycle per write
- addr  input  32  byte address; only addr[7:0] decoded
- wdata  input  32  write data
- gpio_pin  inout  WIDTH  tri-state pins
- rdata  output  32  registered read data
- irq  output  1  level interrupt, high while any IRQ_STATUS bit set

## Operation
- Register map (addr[7:0]), all 32-bit:
  - 0x00 OUT (RW): output value per pin
  - 0x04 OE (RW): 1 = pin driven by OUT[i], 0 = high-Z
  - 0x08 IN (RO): synchronised pin level
  - 0x0C SET (WO, reads 0): OUT |= wdata
  - 0x10 CLR (WO, reads 0): OUT &= ~wdata
  - 0x14 RISE_EN (RW): enable rising-edge capture per pin
  - 0x18 FALL_EN (RW): enable falling-edge capture per pin
  - 0x1C STATUS (R/W1C): latched edge events; writing 1 clears bit, 0 no effect
  - other offsets: reads 0, writes ignored
- Pin drive: gpio_pin[i] = OE[i] ? OUT[i] : 1'bz, combinational from registers.
- Input path: gpio_pin sampled through SYNC_STAGES flops → sync[]; one further flop holds prev[].
- Edge detect: rise[i] = sync[i] & ~prev[i]; fall[i] = ~sync[i] & prev[i].
- STATUS[i] next = (STATUS[i] & ~clr_w1c[i]) | (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); new event wins over simultaneous W1C of same bit.
- Driven pins loop back: IN reflects the pin level, so output toggles raise edges when enabled.
- Changing RISE_EN/FALL_EN never alters existing STATUS bits.
- irq = |STATUS, from registered state (no combinational path from pins or bus).

## Timing
- Reset (async assert, sync-safe deassert by system): OUT=0, OE=0 (all pins high-Z), RISE_EN=0, FALL_EN=0, STATUS=0, sync/prev=0, rdata=0, irq=0.
- Write: register updates on the clk edge where wen=1; effect on gpio_pin visible after that edge.
- Read: rdata updates every cycle from addr, independent of wen; data valid one cycle after addr presented. Read of a register written in the same cycle returns the pre-write value.
- Input latency: pin change before edge k appears in IN after SYNC_STAGES edges; corresponding STATUS bit and irq set one edge later (SYNC_STAGES+1 total).
- Pulses shorter than one clk period may be missed; no glitch filtering.
- Reset mid-operation: all state returns to reset values immediately; pending events lost.

## Test plan
- Reset: hold reset_n=0, pins driven externally → rdata=0, irq=0, gpio_pin all Z; release, read OE → 0.
- Drive: write OE=0xFF, OUT=0xA5 → gpio_pin=0xA5 next cycle; write SET=0x02 then CLR=0x80 → OUT reads 0x27; IN reads 0x27 after SYNC_STAGES cycles.
- Tri-state input: OE=0, external pin3 0→1 → IN[3]=1 after 2 cycles (SYNC_STAGES=2); STATUS stays 0 with RISE_EN=0.
- Edge IRQ: RISE_EN=0x08, FALL_EN=0x01; pin3 rises, pin0 falls → STATUS=0x09 and irq=1 three cycles after change; write STATUS=0x08 → 0x01, irq=1; write 0x01 → irq=0.
- Collision: W1C of STATUS[3] in same cycle as new rising edge on pin3 → STATUS[3] remains 1.
- Width/decode: WIDTH=4, write OUT=0xFFFFFFFF → reads 0x0000000F; read offset 0x40 → 0; addr=0x1000_0004 decodes as OE.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with tri-state pins, synchronised inputs,
// atomic set/clear and per-pin edge interrupts with write-1-to-clear status.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wen,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    inout  wire  [WIDTH-1:0] gpio_pin,
    output logic [31:0]      rdata,
    output logic             irq
);
    logic [WIDTH-1:0] out_q, oe_q, rise_en, fall_en, status, prev, in_q, wd, out_d, status_d, clr;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [7:0]  off;
    logic [31:0] rd_d;
    logic        unused;
    assign off    = addr[7:0];
    assign wd     = wdata[WIDTH-1:0];
    assign unused = ^{addr[31:8], wdata};
    assign in_q   = sync_q[SYNC_STAGES-1];
    assign irq    = |status;
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpio_pin[i] = oe_q[i] ? out_q[i] : 1'bz;
    end
    // A new edge event wins over a simultaneous W1C of the same bit.
    always_comb begin
        clr      = (wen && off == 8'h1C) ? wd : '0;
        status_d = (status & ~clr) | (in_q & ~prev & rise_en) | (~in_q & prev & fall_en);
        out_d    = !wen          ? out_q :
                   off == 8'h00 ? wd :
                   off == 8'h0C ? out_q | wd :
                   off == 8'h10 ? out_q & ~wd : out_q;
    end
    always_comb begin
        case (off)
            8'h00:   rd_d = 32'(out_q);
            8'h04:   rd_d = 32'(oe_q);
            8'h08:   rd_d = 32'(in_q);
            8'h14:   rd_d = 32'(rise_en);
            8'h18:   rd_d = 32'(fall_en);
            8'h1C:   rd_d = 32'(status);
            default: rd_d = '0;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            oe_q    <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            sync_q  <= '0;
            prev    <= '0;
            rdata   <= '0;
        end else begin
            out_q   <= out_d;
            status  <= status_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], gpio_pin};
            prev    <= in_q;
            rdata   <= rd_d;
            if (wen && off == 8'h04) oe_q <= wd;
            if (wen && off == 8'h14) rise_en <= wd;
            if (wen && off == 8'h18) fall_en <= wd;
        end
    end
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: random and directed stimulus for gpio_bank, checked against a
// register-level model that tracks pin history as a queue of sampled levels.
module tb_gpio_bank;
    localparam int W = 8;
    localparam int S = 2;
    logic          clk = 0, reset_n = 0, wen = 0;
    logic [31:0]   addr = 0, wdata = 0;
    wire  [W-1:0]  gpio_pin;
    logic [31:0]   rdata;
    logic          irq;
    logic [W-1:0]  ext_val = 0, ext_en = '1;
    logic [W-1:0]  m_out, m_oe, m_ren, m_fen, m_st;
    logic [W-1:0]  hist[$];
    logic [31:0]   m_rd;
    int            errs = 0, checks = 0;

    gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .wen(wen), .addr(addr), .wdata(wdata),
        .gpio_pin(gpio_pin), .rdata(rdata), .irq(irq)
    );

    for (genvar i = 0; i < W; i++) begin : g_ext
        assign gpio_pin[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_out = 0; m_oe = 0; m_ren = 0; m_fen = 0; m_st = 0; m_rd = 0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back('0);
    endfunction

    // hist[0] is the newest sampled level; IN is the level sampled S-1 edges earlier.
    function automatic logic [31:0] model_read(input logic [7:0] o);
        case (o)
            8'h00:   return 32'(m_out);
            8'h04:   return 32'(m_oe);
            8'h08:   return 32'(hist[S-1]);
            8'h14:   return 32'(m_ren);
            8'h18:   return 32'(m_fen);
            8'h1C:   return 32'(m_st);
            default: return 0;
        endcase
    endfunction

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [W-1:0] ev);
        logic [W-1:0] pin_s, rise, fall, wd;
        logic [7:0]   o;
        wen = w; addr = a; wdata = d; ext_val = ev;
        @(posedge clk);
        o     = a[7:0];
        wd    = d[W-1:0];
        pin_s = (m_oe & m_out) | (~m_oe & ev);
        m_rd  = model_read(o);
        rise  = hist[S-1] & ~hist[S];
        fall  = ~hist[S-1] & hist[S];
        m_st  = (m_st & ~((w && o == 8'h1C) ? wd : '0)) | (rise & m_ren) | (fall & m_fen);
        if (w) begin
            case (o)
                8'h00: m_out = wd;
                8'h04: m_oe  = wd;
                8'h0C: m_out = m_out | wd;
                8'h10: m_out = m_out & ~wd;
                8'h14: m_ren = wd;
                8'h18: m_fen = wd;
                default: ;
            endcase
        end
        hist.push_front(pin_s);
        void'(hist.pop_back());
        #1 ext_en = ~m_oe;
        @(negedge clk);
        chk("rdata", rdata, m_rd);
        chk("irq", 32'(irq), 32'(|m_st));
        chk("pin", 32'(gpio_pin), 32'((m_oe & m_out) | (~m_oe & ext_val)));
    endtask

    initial begin
        int offs[10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h03};
        logic [W-1:0] ev;
        model_reset();
        ext_val = 8'h5A;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_pin_hiz", 32'(gpio_pin), 32'h5A);
        reset_n = 1;
        step(0, 32'h04, 0, 8'h5A);
        step(0, 32'h04, 0, 8'h5A);
        chk("rst_oe", rdata, 0);
        // Drive and atomic set/clear
        step(1, 32'h04, 32'hFF, 0);
        step(1, 32'h00, 32'hA5, 0);
        chk("drive_pin", 32'(gpio_pin), 32'hA5);
        step(1, 32'h0C, 32'h02, 0);
        step(1, 32'h10, 32'h80, 0);
        step(0, 32'h00, 0, 0);
        chk("out_27", rdata, 32'h27);
        repeat (3) step(0, 32'h08, 0, 0);
        chk("in_27", rdata, 32'h27);
        // Tri-state input, no enables
        step(1, 32'h04, 0, 0);
        repeat (4) step(0, 32'h08, 0, 0);
        step(0, 32'h08, 0, 8'h08);
        repeat (3) step(0, 32'h08, 0, 8'h08);
        chk("in_pin3", rdata, 32'h08);
        step(0, 32'h1C, 0, 8'h08);
        chk("status_off", rdata, 0);
        // Edge interrupts
        repeat (4) step(0, 32'h08, 0, 8'h01);
        step(1, 32'h14, 32'h08, 8'h01);
        step(1, 32'h18, 32'h01, 8'h01);
        step(0, 32'h1C, 0, 8'h08);
        step(0, 32'h1C, 0, 8'h08);
        chk("irq_early", 32'(irq), 0);
        step(0, 32'h1C, 0, 8'h08);
        chk("irq_set", 32'(irq), 1);
        step(0, 32'h1C, 0, 8'h08);
        chk("status_09", rdata, 32'h09);
        step(1, 32'h1C, 32'h08, 8'h08);
        step(0, 32'h1C, 0, 8'h08);
        chk("status_01", rdata, 32'h01);
        chk("irq_still", 32'(irq), 1);
        step(1, 32'h1C, 32'h01, 8'h08);
        chk("irq_clear", 32'(irq), 0);
        // Collision: W1C on the same edge a new rise lands
        repeat (4) step(0, 32'h00, 0, 8'h00);
        step(1, 32'h1C, 32'hFF, 8'h08);
        step(0, 32'h00, 0, 8'h08);
        step(1, 32'h1C, 32'h08, 8'h08);
        step(0, 32'h1C, 0, 8'h08);
        chk("collision", rdata & 32'h08, 32'h08);
        // Width and decode
        step(1, 32'h00, 32'hFFFF_FFFF, 8'h08);
        step(0, 32'h00, 0, 8'h08);
        chk("width_mask", rdata, 32'h0000_00FF);
        step(0, 32'h40, 0, 8'h08);
        chk("hole_40", rdata, 0);
        step(1, 32'h1000_0004, 32'h0F, 8'h08);
        step(0, 32'h04, 0, 8'h08);
        chk("alias_oe", rdata, 32'h0F);
        // Randomised traffic with one asynchronous reset in the middle
        ev = 0;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2 reset_n = 0;
                #1;
                chk("mid_rst_rdata", rdata, 0);
                chk("mid_rst_irq", 32'(irq), 0);
                model_reset();
                ext_en = '1;
                #1 reset_n = 1;
            end
            if ($urandom_range(0, 3) == 0) ev = W'($urandom);
            step(1'($urandom_range(0, 1)),
                 {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 8'(offs[$urandom_range(0, 9)])},
                 $urandom, ev);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
